// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and default parameters for the program loader
package reflet_loader_pkg;

  localparam int          DEFAULT_DEPTH = 128;
  localparam logic [31:0] DEFAULT_MAGIC = 32'h4153524D;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MAGIC = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_CLEAR = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERROR = 3'd5;

  // Header byte 0 is the most significant byte of the magic word.
  function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = magic[31:24];
      2'd1:    b = magic[23:16];
      2'd2:    b = magic[15:8];
      default: b = magic[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream handshake between an image source and the loader
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader_ram.sv
// rtl/prog_loader_ram.sv - program store: one write port, one registered read port, no reset
module prog_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Same-address read and write on one edge returns the previous contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - validates the image header, streams the image into RAM and zero-fills the rest
module prog_loader
  import reflet_loader_pkg::*;
#(
  parameter int          DEPTH = DEFAULT_DEPTH,
  parameter logic [31:0] MAGIC = DEFAULT_MAGIC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  prog_loader_if.slave             in_bus,
  input  logic                     enable_out,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [7:0]               dataOut,
  output logic                     loading,
  output logic                     done,
  output logic                     error
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW-1:0] PTR_END = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [1:0]    r_midx;

  logic          w_fire;
  logic          w_magic_ok;
  logic          w_ptr_end;
  logic          w_we;
  logic [7:0]    w_wdata;
  logic [7:0]    w_rdata;

  assign in_bus.in_ready = (r_state == ST_MAGIC) || (r_state == ST_LOAD);
  assign w_fire          = in_bus.in_valid && in_bus.in_ready;
  // A header byte flagged as last can never lead to a complete image.
  assign w_magic_ok      = (in_bus.in_data == magic_byte(MAGIC, r_midx)) && !in_bus.in_last;
  assign w_ptr_end       = (r_wr_ptr == PTR_END);

  assign w_we    = ((r_state == ST_MAGIC) && w_fire && w_magic_ok)
                || ((r_state == ST_LOAD) && w_fire)
                || (r_state == ST_CLEAR);
  assign w_wdata = (r_state == ST_CLEAR) ? 8'h00 : in_bus.in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_midx   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start) begin
            r_state  <= ST_MAGIC;
            r_wr_ptr <= '0;
            r_midx   <= 2'd0;
          end
        end
        ST_MAGIC: begin
          if (w_fire) begin
            if (w_magic_ok) begin
              r_wr_ptr <= r_wr_ptr + PTR_ONE;
              r_midx   <= r_midx + 2'd1;
              if (r_midx == 2'd3) r_state <= ST_LOAD;
            end else begin
              r_state <= ST_ERROR;
            end
          end
        end
        ST_LOAD: begin
          if (w_fire) begin
            // The final address ends the load regardless of in_last; the pointer never wraps.
            if (w_ptr_end) begin
              r_state <= ST_DONE;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_ONE;
              if (in_bus.in_last) r_state <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          if (w_ptr_end) r_state  <= ST_DONE;
          else           r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (addr),
    .o_rdata (w_rdata)
  );

  assign loading = (r_state == ST_MAGIC) || (r_state == ST_LOAD) || (r_state == ST_CLEAR);
  assign done    = (r_state == ST_DONE);
  assign error   = (r_state == ST_ERROR);
  // RAM is never reset, so its contents stay hidden until a complete image is resident.
  assign dataOut = (enable_out && done) ? w_rdata : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against an image model
module tb_prog_loader;

  localparam int          DEPTH = 128;
  localparam logic [31:0] MAGIC = 32'h4153524D;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       load_start = 1'b0;
  logic       enable_out = 1'b0;
  logic [6:0] addr       = '0;
  logic [7:0] dataOut;
  logic       loading;
  logic       done;
  logic       error;

  prog_loader_if bus ();

  prog_loader #(.DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_bus     (bus),
    .enable_out (enable_out),
    .addr       (addr),
    .dataOut    (dataOut),
    .loading    (loading),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] img[$];
  logic [7:0] hdr[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gaps_max,
                           input bit pulse_ls);
    bit ok = 0;
    int w  = 0;
    repeat ($urandom_range(0, gaps_max)) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      if (pulse_ls) load_start = 1'($urandom_range(0, 1));
      tick();
    end
    load_start   = 1'b0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!ok && w < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      tick();
      w++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [7:0] exp_mem(input int a);
    return (a < img.size()) ? img[a] : 8'h00;
  endfunction

  task automatic check_image();
    for (int a = 0; a < DEPTH; a++) begin
      enable_out = 1'b1;
      addr       = 7'(a);
      tick();
      check($sformatf("mem[%0d]", a), 32'(dataOut), 32'(exp_mem(a)));
    end
  endtask

  // Loads header + payload; expects DONE after DEPTH - image_size zero-fill cycles.
  task automatic load_image(input logic [7:0] pay[$], input bit last_flag, input int gaps,
                            input bit pulse_ls);
    int cnt = 0;
    int n;
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back(hdr[i]);
    foreach (pay[i]) img.push_back(pay[i]);
    n = img.size();
    pulse_start();
    check("loading_after_start", 32'(loading), 32'd1);
    for (int i = 0; i < n; i++)
      send_byte(img[i], (i == n - 1) && last_flag, gaps, pulse_ls && (i >= 4) && (i < n - 1));
    while (!done && cnt < DEPTH + 10) begin
      tick();
      cnt++;
    end
    check("clear_cycles", 32'(cnt), 32'(DEPTH - n));
    check("done_loaded", 32'(done), 32'd1);
    check("ready_in_done", 32'(bus.in_ready), 32'd0);
    check("loading_in_done", 32'(loading), 32'd0);
    check_image();
  endtask

  task automatic rand_payload(input int len, output logic [7:0] pay[$]);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pay[$];
    logic [7:0] bad;
    int         k;

    hdr[0] = 8'h41; hdr[1] = 8'h53; hdr[2] = 8'h52; hdr[3] = 8'h4D;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    enable_out   = 1'b1;

    repeat (3) tick();
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_dataout", 32'(dataOut), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Reference image: two payload bytes, last on the second.
    pay = '{8'h14, 8'h3C};
    load_image(pay, 1'b1, 0, 1'b0);

    enable_out = 1'b0;
    addr       = 7'd1;
    tick();
    check("oe_low", 32'(dataOut), 32'd0);
    enable_out = 1'b1;
    tick();
    check("oe_addr1", 32'(dataOut), 32'h53);

    // Header mismatch on the third byte.
    pulse_start();
    send_byte(8'h41, 1'b0, 0, 1'b0);
    send_byte(8'h53, 1'b0, 0, 1'b0);
    send_byte(8'h58, 1'b0, 0, 1'b0);
    check("err_flag", 32'(error), 32'd1);
    check("err_ready", 32'(bus.in_ready), 32'd0);
    check("err_loading", 32'(loading), 32'd0);
    addr = 7'd2;
    tick();
    check("err_read", 32'(dataOut), 32'd0);
    pulse_start();
    check("restart_loading", 32'(loading), 32'd1);
    check("restart_error", 32'(error), 32'd0);

    // Random header failures: wrong byte or premature last at a random index.
    for (int t = 0; t < 6; t++) begin
      if (!error) send_byte(8'h00, 1'b0, 0, 1'b0);
      pulse_start();
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) send_byte(hdr[i], 1'b0, 1, 1'b0);
      if (t % 2 == 0) begin
        bad = hdr[k] ^ 8'($urandom_range(1, 255));
        send_byte(bad, 1'b0, 1, 1'b0);
      end else begin
        send_byte(hdr[k], 1'b1, 1, 1'b0);
      end
      check($sformatf("hdr_err_%0d", t), 32'(error), 32'd1);
      check($sformatf("hdr_err_ld_%0d", t), 32'(loading), 32'd0);
    end

    // Full-size image with no last: DONE right after the final address.
    rand_payload(DEPTH - 4, pay);
    load_image(pay, 1'b0, 1, 1'b0);
    bus.in_data  = 8'hEE;
    bus.in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("extra_ready", 32'(bus.in_ready), 32'd0);
      check("extra_done", 32'(done), 32'd1);
    end
    bus.in_valid = 1'b0;
    addr = 7'(DEPTH - 1);
    tick();
    check("extra_not_stored", 32'(dataOut), 32'(exp_mem(DEPTH - 1)));

    // Full-size image with last on the final address.
    rand_payload(DEPTH - 4, pay);
    load_image(pay, 1'b1, 1, 1'b1);

    // Random lengths, random valid gaps, ignored load_start pulses.
    for (int t = 0; t < 5; t++) begin
      rand_payload($urandom_range(1, DEPTH - 5), pay);
      load_image(pay, 1'b1, 3, 1'b1);
    end

    // Asynchronous reset after the tenth byte.
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte((i < 4) ? hdr[i] : 8'($urandom), 1'b0, 1, 1'b0);
    enable_out = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_loading", 32'(loading), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_dataout", 32'(dataOut), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.in_data  = 8'h41;
    bus.in_valid = 1'b1;
    repeat (4) begin
      tick();
      check("idle_hold_loading", 32'(loading), 32'd0);
      check("idle_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;

    rand_payload($urandom_range(1, 40), pay);
    load_image(pay, 1'b1, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128: program memory size in bytes, a power of two; address width AW = log2(DEPTH), 7 at default.
REQ-002 SHALL have parameter MAGIC, default 32'h4153524D: the four-byte image header "ASRM", first byte in bits 31:24.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 load_start  in  1  single-cycle request to begin loading an image.
REQ-006 in_data  in  8  image byte from the byte source.
REQ-007 in_valid  in  1  in_data is valid.
REQ-008 in_last  in  1  qualifies in_data as the final image byte.
REQ-009 in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-010 enable_out  in  1  read-port output enable.
REQ-011 addr  in  AW  read address.
REQ-012 dataOut  out  8  read data; 8'h00 when enable_out=0 or done=0.
REQ-013 loading  out  1  high in states MAGIC, LOAD and CLEAR.
REQ-014 done  out  1  high in state DONE; a valid image is resident.
REQ-015 error  out  1  high in state ERROR.

Function
REQ-016 SHALL implement states IDLE, MAGIC, LOAD, CLEAR, DONE and ERROR.
REQ-017 IDLE/DONE/ERROR + load_start -> MAGIC with wr_ptr=0 and magic index=0; load_start SHALL be ignored in MAGIC, LOAD and CLEAR.
REQ-018 in_ready SHALL be 1 only in MAGIC and LOAD.
REQ-019 In MAGIC, each accepted byte SHALL be compared with MAGIC byte [index] and written to wr_ptr; wr_ptr and index then increment.
REQ-020 In MAGIC, a mismatching byte, or in_last=1 on any magic byte, SHALL go to ERROR on that edge, and that byte SHALL NOT be written.
REQ-021 Acceptance of the 4th matching magic byte SHALL go to LOAD.
REQ-022 In LOAD, each accepted byte SHALL be written to wr_ptr, and wr_ptr then increments.
REQ-023 In LOAD, an accepted byte with in_last=1 SHALL go to CLEAR.
REQ-024 In LOAD, a byte written at address DEPTH-1 SHALL go to DONE, whether or not in_last is set; wr_ptr SHALL NOT wrap.
REQ-025 CLEAR SHALL write 8'h00 to wr_ptr once per cycle, then increment wr_ptr; writing address DEPTH-1 -> DONE.
REQ-026 A byte with in_last=1 at address DEPTH-1 SHALL go directly to DONE.
REQ-027 Memory read SHALL be synchronous: the registered data for addr is available the cycle after the edge.
REQ-028 dataOut SHALL equal the registered data gated by enable_out and done, combinationally.
REQ-029 A read and write to the same address on the same edge SHALL return the old data.
REQ-030 in_valid while in_ready=0 SHALL be ignored; no byte is consumed.
REQ-031 Reads while loading=1 SHALL return 8'h00.

Reset
REQ-032 reset low SHALL force, asynchronously: IDLE, wr_ptr=0, magic index=0, loading=0, done=0, error=0, in_ready=0, dataOut=0.
REQ-033 Memory contents SHALL NOT be reset; this is masked by REQ-012.
REQ-034 Reset asserted mid-load SHALL abort the load; after release the block SHALL remain in IDLE until load_start.

Structure
REQ-035 A shared package reflet_loader_pkg SHALL hold the state enum, the default MAGIC constant and the default DEPTH.
REQ-036 Storage SHALL be a sub-module prog_ram.
REQ-037 prog_ram SHALL have one write port, one registered read port and no reset.
REQ-038 The FSM, pointers and output gating SHALL reside in prog_loader.

Verification
REQ-039 Reset, then load_start, then bytes 41 53 52 4D 14 3C with last on 3C -> CLEAR for 122 cycles, then done=1; reads: addr 0=41, addr 5=3C, addr 6..127=00.
REQ-040 load_start, then bytes 41 53 58 -> error=1 and in_ready=0; reading addr 2 returns 00; a new load_start -> MAGIC, with error=0 from the next cycle.
REQ-041 A 128-byte stream with valid magic and no last -> done=1 immediately after byte 127, in_ready=0; a 129th in_valid is not consumed.
REQ-042 in_valid toggling randomly during LOAD -> only handshaked bytes are stored, in order, with no gaps.
REQ-043 reset pulsed low after the 10th byte -> all outputs 0 immediately; state IDLE; load_start pulses during LOAD are ignored.
REQ-044 In DONE with enable_out=0 -> dataOut=00; enable_out=1 with addr=1 -> 53 one cycle after addr is applied.
